store_byte_serializer: RTL and testbench

- Store-side counterpart of the load-path sign extender. It narrows a 32-bit register value to a byte, halfword or word store, then issues it one byte per transfer on an 8-bit memory write port.
- Sits between the datapath's store request (sb/sh/sw) and a byte-wide data memory.
- Little-endian: byte k = data[8k+7:8k], written to addr+k.

---
 rtl/store_byte_serializer.sv | 117 +++++++++++
 tb/tb_store_byte_serializer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_byte_serializer.sv
// Narrows a register value to sb/sh/sw and writes it one byte per handshake.
// Optional misaligned-request trap enabled by defining MISALIGN_TRAP_EN.
module store_byte_serializer #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [1:0]        req_size,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_byte,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      RESP
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [31:0]       data;
   logic [CNT_W-1:0]  idx;
   logic [CNT_W-1:0]  last;

   logic [CNT_W-1:0]  nxt;
   logic [CNT_W-1:0]  req_last;
   logic [7:0]        nxt_byte;
   logic              req_fire;
   logic              illegal;

   always_comb begin
      req_fire = req_valid & req_ready;
      nxt      = idx + CNT_W'(1);
      nxt_byte = 8'(data >> {nxt, 3'b000});
      unique case (req_size)
         2'b00:   req_last = CNT_W'(0);
         2'b01:   req_last = CNT_W'(1);
         default: req_last = CNT_W'(3);
      endcase
      illegal = (req_size == 2'b11);
`ifdef MISALIGN_TRAP_EN
      if (req_size == 2'b01 && req_addr[0])
         illegal = 1'b1;
      if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
         illegal = 1'b1;
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_byte  <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         base      <= '0;
         data      <= '0;
         idx       <= '0;
         last      <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_fire) begin
                  base      <= req_addr;
                  data      <= req_data;
                  idx       <= '0;
                  last      <= req_last;
                  req_ready <= 1'b0;
                  if (illegal) begin
                     err   <= 1'b1;
                     state <= RESP;
                  end else begin
                     mem_valid <= 1'b1;
                     mem_addr  <= req_addr;
                     mem_byte  <= req_data[7:0];
                     state     <= SEND;
                  end
               end
            end
            SEND: begin
               // Outputs only move on a handshake, so they hold under stall.
               if (mem_ready) begin
                  if (idx == last) begin
                     mem_valid <= 1'b0;
                     done      <= 1'b1;
                     state     <= RESP;
                  end else begin
                     idx      <= nxt;
                     mem_addr <= base + ADDR_W'(nxt);
                     mem_byte <= nxt_byte;
                  end
               end
            end
            RESP: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_store_byte_serializer.sv
// Scoreboard bench for store_byte_serializer.
// Honours MISALIGN_TRAP_EN when the same macro is defined for the DUT.
module tb_store_byte_serializer;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic [1:0]  req_size = '0;
   logic        mem_valid;
   logic        mem_ready = 1'b1;
   logic [31:0] mem_addr;
   logic [7:0]  mem_byte;
   logic        done;
   logic        err;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  b;
   } wr_t;

   wr_t sb_q[$];

   store_byte_serializer #(.ADDR_W(32), .CNT_W(2)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_byte(mem_byte),
      .done(done), .err(err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   task automatic push_bytes(input logic [31:0] a, input logic [31:0] d,
                             input int n);
      wr_t e;
      for (int i = 0; i < n; i++) begin
         e.addr = a + 32'(i);
         e.b    = d[8*i +: 8];
         sb_q.push_back(e);
      end
   endtask

   // Request accepted at the posedge inside; returns #1 after it.
   task automatic drive_req(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] s);
      @(negedge CLK);
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      req_size  = s;
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      tests_run++;
      if ({req_ready, mem_valid, done, err} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL reset_ctl: got %b want 1000",
                  {req_ready, mem_valid, done, err});
      end
      tests_run++;
      if ({mem_addr, mem_byte} !== 40'h0) begin
         tests_failed++;
         $display("FAIL reset_data: got %h want 0", {mem_addr, mem_byte});
      end
   endtask

   task automatic test_word();
      logic [31:0] addrs[2];
      logic [31:0] datas[2];
      wr_t e;
      int  writes;
      bit  fin;
      addrs[0] = 32'h0000_0100; datas[0] = 32'hDEAD_BEEF;
      addrs[1] = 32'hFFFF_FFFE; datas[1] = 32'hCAFE_F00D;
      for (int r = 0; r < 2; r++) begin
         writes = 0;
         fin = 0;
         push_bytes(addrs[r], datas[r], 4);
         drive_req(addrs[r], datas[r], 2'b10);
         for (int k = 1; k <= 20 && !fin; k++) begin
            @(negedge CLK);
            if (mem_valid && mem_ready) begin
               tests_run++;
               if (sb_q.size() == 0) begin
                  tests_failed++;
                  $display("FAIL word_extra: got write @%h want none", mem_addr);
               end else begin
                  e = sb_q.pop_front();
                  if ({mem_addr, mem_byte} !== {e.addr, e.b}) begin
                     tests_failed++;
                     $display("FAIL word_byte: got %h@%h want %h@%h",
                              mem_byte, mem_addr, e.b, e.addr);
                  end
               end
               tests_run++;
               if (k != writes + 1) begin
                  tests_failed++;
                  $display("FAIL word_cycle: got %0d want %0d", k, writes + 1);
               end
               writes++;
            end
            if (done) begin
               fin = 1;
               tests_run++;
               if (k != 5 || err !== 1'b0) begin
                  tests_failed++;
                  $display("FAIL word_done: got cyc %0d err %b want 5 0", k, err);
               end
            end
         end
         tests_run++;
         if (!fin || writes != 4) begin
            tests_failed++;
            $display("FAIL word_count: got done %0d writes %0d want 1 4",
                     fin, writes);
         end
         @(negedge CLK);
         tests_run++;
         if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL word_ready: got %b want 1", req_ready);
         end
      end
   endtask

   task automatic test_narrow();
      logic [31:0] addrs[2];
      logic [31:0] datas[2];
      logic [1:0]  sizes[2];
      int          nb[2];
      wr_t e;
      int  writes;
      bit  fin;
      addrs[0] = 32'h7;  datas[0] = 32'hFFFF_FF80; sizes[0] = 2'b00; nb[0] = 1;
      addrs[1] = 32'h20; datas[1] = 32'h1234_8001; sizes[1] = 2'b01; nb[1] = 2;
      for (int r = 0; r < 2; r++) begin
         writes = 0;
         fin = 0;
         push_bytes(addrs[r], datas[r], nb[r]);
         drive_req(addrs[r], datas[r], sizes[r]);
         for (int k = 1; k <= 20 && !fin; k++) begin
            @(negedge CLK);
            if (mem_valid && mem_ready) begin
               tests_run++;
               if (sb_q.size() == 0) begin
                  tests_failed++;
                  $display("FAIL narrow_extra: got %h@%h want none",
                           mem_byte, mem_addr);
               end else begin
                  e = sb_q.pop_front();
                  if ({mem_addr, mem_byte} !== {e.addr, e.b}) begin
                     tests_failed++;
                     $display("FAIL narrow_byte: got %h@%h want %h@%h",
                              mem_byte, mem_addr, e.b, e.addr);
                  end
               end
               writes++;
            end
            if (done) begin
               fin = 1;
               tests_run++;
               if (k != nb[r] + 1 || err !== 1'b0) begin
                  tests_failed++;
                  $display("FAIL narrow_done: got cyc %0d err %b want %0d 0",
                           k, err, nb[r] + 1);
               end
            end
         end
         tests_run++;
         if (!fin || writes != nb[r]) begin
            tests_failed++;
            $display("FAIL narrow_count: got done %0d writes %0d want 1 %0d",
                     fin, writes, nb[r]);
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_backpressure();
      wr_t e;
      int  writes = 0;
      int  stall = 0;
      int  dones = 0;
      bit  fin = 0;
      push_bytes(32'h300, 32'h1122_3344, 4);
      drive_req(32'h300, 32'h1122_3344, 2'b10);
      for (int k = 1; k <= 30 && !fin; k++) begin
         @(negedge CLK);
         if (writes == 1 && stall < 3) begin
            mem_ready = 1'b0;
            stall++;
            tests_run++;
            if ({mem_valid, mem_addr, mem_byte} !== {1'b1, 32'h301, 8'h33}) begin
               tests_failed++;
               $display("FAIL bp_hold: got %b %h %h want 1 301 33",
                        mem_valid, mem_addr, mem_byte);
            end
         end else begin
            mem_ready = 1'b1;
         end
         if (mem_valid && mem_ready) begin
            tests_run++;
            if (sb_q.size() == 0) begin
               tests_failed++;
               $display("FAIL bp_extra: got %h@%h want none", mem_byte, mem_addr);
            end else begin
               e = sb_q.pop_front();
               if ({mem_addr, mem_byte} !== {e.addr, e.b}) begin
                  tests_failed++;
                  $display("FAIL bp_byte: got %h@%h want %h@%h",
                           mem_byte, mem_addr, e.b, e.addr);
               end
            end
            writes++;
         end
         if (done) begin
            fin = 1;
            dones++;
            tests_run++;
            if (k != 8) begin
               tests_failed++;
               $display("FAIL bp_done: got cyc %0d want 8", k);
            end
         end
      end
      mem_ready = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         if (done) dones++;
         if (mem_valid) writes++;
      end
      tests_run++;
      if (writes != 4 || dones != 1) begin
         tests_failed++;
         $display("FAIL bp_count: got writes %0d dones %0d want 4 1",
                  writes, dones);
      end
   endtask

   task automatic test_illegal();
      drive_req(32'h40, 32'hAAAA_5555, 2'b11);
      @(negedge CLK);
      tests_run++;
      if ({err, done, mem_valid, req_ready} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL illegal_t1: got %b want 1000",
                  {err, done, mem_valid, req_ready});
      end
      @(negedge CLK);
      tests_run++;
      if ({err, done, mem_valid, req_ready} !== 4'b0001) begin
         tests_failed++;
         $display("FAIL illegal_t2: got %b want 0001",
                  {err, done, mem_valid, req_ready});
      end
   endtask

   task automatic test_misalign();
      wr_t e;
      int  writes = 0;
      int  errs = 0;
      bit  fin = 0;
      int  want_writes;
      int  want_cyc;
`ifdef MISALIGN_TRAP_EN
      want_writes = 0;
      want_cyc = 1;
`else
      want_writes = 2;
      want_cyc = 3;
      push_bytes(32'h21, 32'hABCD_5A6B, 2);
`endif
      drive_req(32'h21, 32'hABCD_5A6B, 2'b01);
      for (int k = 1; k <= 20 && !fin; k++) begin
         @(negedge CLK);
         if (mem_valid && mem_ready) begin
            tests_run++;
            if (sb_q.size() == 0) begin
               tests_failed++;
               $display("FAIL mis_extra: got %h@%h want none", mem_byte, mem_addr);
            end else begin
               e = sb_q.pop_front();
               if ({mem_addr, mem_byte} !== {e.addr, e.b}) begin
                  tests_failed++;
                  $display("FAIL mis_byte: got %h@%h want %h@%h",
                           mem_byte, mem_addr, e.b, e.addr);
               end
            end
            writes++;
         end
         if (err) errs++;
         if (done || err) begin
            fin = 1;
            tests_run++;
            if (k != want_cyc) begin
               tests_failed++;
               $display("FAIL mis_cyc: got %0d want %0d", k, want_cyc);
            end
         end
      end
      tests_run++;
      if (!fin || writes != want_writes || errs != (want_writes == 0 ? 1 : 0))
      begin
         tests_failed++;
         $display("FAIL mis_count: got writes %0d errs %0d want %0d %0d",
                  writes, errs, want_writes, (want_writes == 0 ? 1 : 0));
      end
      @(negedge CLK);
   endtask

   task automatic test_reset_midop();
      wr_t e;
      int  writes = 0;
      int  stray = 0;
      bit  fin = 0;
      push_bytes(32'h200, 32'h5566_7788, 4);
      drive_req(32'h200, 32'h5566_7788, 2'b10);
      @(negedge CLK);
      tests_run++;
      e = sb_q.pop_front();
      if ({mem_valid, mem_addr, mem_byte} !== {1'b1, e.addr, e.b}) begin
         tests_failed++;
         $display("FAIL midop_b0: got %b %h %h want 1 %h %h",
                  mem_valid, mem_addr, mem_byte, e.addr, e.b);
      end
      @(negedge CLK);
      RST = 1'b1;
      #1;
      tests_run++;
      if ({req_ready, mem_valid, done, err, mem_addr, mem_byte} !==
          {4'b1000, 40'h0}) begin
         tests_failed++;
         $display("FAIL midop_async: got %b %h %h want 1000 0 0",
                  {req_ready, mem_valid, done, err}, mem_addr, mem_byte);
      end
      sb_q.delete();
      @(negedge CLK);
      RST = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         if (mem_valid || done || err) stray++;
      end
      tests_run++;
      if (stray != 0) begin
         tests_failed++;
         $display("FAIL midop_stray: got %0d want 0", stray);
      end
      push_bytes(32'h9, 32'h0000_00A5, 1);
      drive_req(32'h9, 32'h0000_00A5, 2'b00);
      for (int k = 1; k <= 20 && !fin; k++) begin
         @(negedge CLK);
         if (mem_valid && mem_ready) begin
            tests_run++;
            if (sb_q.size() == 0) begin
               tests_failed++;
               $display("FAIL midop_extra: got %h@%h want none",
                        mem_byte, mem_addr);
            end else begin
               e = sb_q.pop_front();
               if ({mem_addr, mem_byte} !== {e.addr, e.b}) begin
                  tests_failed++;
                  $display("FAIL midop_byte: got %h@%h want %h@%h",
                           mem_byte, mem_addr, e.b, e.addr);
               end
            end
            writes++;
         end
         if (done) fin = 1;
      end
      tests_run++;
      if (!fin || writes != 1) begin
         tests_failed++;
         $display("FAIL midop_after: got done %0d writes %0d want 1 1",
                  fin, writes);
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_narrow();
      test_backpressure();
      test_illegal();
      test_misalign();
      test_reset_midop();
      tests_run++;
      if (sb_q.size() != 0) begin
         tests_failed++;
         $display("FAIL leftover: got %0d want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
